// File: rtl/reg_acc_ctrl.sv
// Register-bank access controller: arbitrates the shared register bus between
// single SPI accesses (one-entry slot) and the power-up efuse loader walk.
module reg_acc_ctrl #(
    parameter int              DW           = 8,
    parameter int              AW           = 8,
    parameter int              CRC_W        = 8,
    parameter int              EF_NUM       = 4,
    parameter logic [AW-1:0]   EF_BASE_ADDR = 8'h40,
    parameter int              EF_TMO       = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_spi_req,
    input  logic             i_spi_wr,
    input  logic [AW-1:0]    i_spi_addr,
    input  logic [DW-1:0]    i_spi_wdata,
    input  logic [CRC_W-1:0] i_spi_crc,
    output logic             o_spi_ack,
    output logic [DW-1:0]    o_spi_rdata,
    output logic [CRC_W-1:0] o_spi_rcrc,
    output logic             o_spi_err,
    input  logic             i_ef_start,
    output logic             o_ef_rd,
    output logic [3:0]       o_ef_idx,
    input  logic             i_efuse_vld,
    input  logic [DW-1:0]    i_efuse_data,
    input  logic [CRC_W-1:0] i_efuse_crc,
    output logic             o_ef_busy,
    output logic             o_ef_done,
    output logic             o_ef_err,
    output logic             o_wen,
    output logic             o_ren,
    output logic [AW-1:0]    o_addr,
    output logic [DW-1:0]    o_wdata,
    output logic [CRC_W-1:0] o_crc_data,
    output logic             o_spi_ctrl_reg_en,
    output logic             o_efuse_ctrl_reg_en,
    input  logic [DW-1:0]    i_rdata,
    input  logic [CRC_W-1:0] i_rcrc
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SPI_ACC = 3'd1,
        ST_SPI_ACK = 3'd2,
        ST_EF_RD   = 3'd3,
        ST_EF_WAIT = 3'd4,
        ST_EF_WR   = 3'd5
    } state_e;

    state_e             state_r, state_s;
    logic               slot_v_r, slot_v_s, slot_wr_r, slot_wr_s;
    logic [AW-1:0]      slot_addr_r, slot_addr_s;
    logic [DW-1:0]      slot_wdata_r, slot_wdata_s;
    logic [CRC_W-1:0]   slot_crc_r, slot_crc_s;
    logic               ef_pend_r, ef_pend_s;
    logic [3:0]         idx_r, idx_s;
    logic [7:0]         tmo_cnt_r, tmo_cnt_s;
    logic [DW-1:0]      spi_rdata_r, spi_rdata_s;
    logic [CRC_W-1:0]   spi_rcrc_r, spi_rcrc_s;
    logic               spi_err_r, spi_err_s;
    logic               ef_done_r, ef_done_s, ef_err_r, ef_err_s;
    logic               in_ef_s;

    logic               spi_ack_r, spi_ack_s, ef_rd_r, ef_rd_s, ef_busy_r, ef_busy_s;
    logic [3:0]         ef_idx_r, ef_idx_s;
    logic               wen_r, wen_s, ren_r, ren_s, spi_en_r, spi_en_s, ef_en_r, ef_en_s;
    logic [AW-1:0]      addr_r, addr_s;
    logic [DW-1:0]      wdata_r, wdata_s;
    logic [CRC_W-1:0]   crc_r, crc_s;

    assign in_ef_s = (state_r == ST_EF_RD) || (state_r == ST_EF_WAIT) || (state_r == ST_EF_WR);

    // Next-state logic: slot capture, start latching, sequencing and sticky status.
    always_comb begin
        state_s      = state_r;
        slot_v_s     = slot_v_r;
        slot_wr_s    = slot_wr_r;
        slot_addr_s  = slot_addr_r;
        slot_wdata_s = slot_wdata_r;
        slot_crc_s   = slot_crc_r;
        ef_pend_s    = ef_pend_r;
        idx_s        = idx_r;
        tmo_cnt_s    = tmo_cnt_r;
        spi_rdata_s  = spi_rdata_r;
        spi_rcrc_s   = spi_rcrc_r;
        spi_err_s    = 1'b0;
        ef_done_s    = ef_done_r;
        ef_err_s     = ef_err_r;

        if (i_spi_req && slot_v_r) begin
            spi_err_s = 1'b1;
        end else if (i_spi_req) begin
            slot_v_s     = 1'b1;
            slot_wr_s    = i_spi_wr;
            slot_addr_s  = i_spi_addr;
            slot_wdata_s = i_spi_wdata;
            slot_crc_s   = i_spi_crc;
        end else begin
            slot_v_s = slot_v_r;
        end

        if (i_ef_start && !in_ef_s) begin
            ef_pend_s = 1'b1;
        end else begin
            ef_pend_s = ef_pend_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (ef_pend_r) begin
                    state_s   = ST_EF_RD;
                    ef_pend_s = 1'b0;
                    idx_s     = 4'd0;
                    ef_done_s = 1'b0;
                    ef_err_s  = 1'b0;
                end else if (slot_v_r) begin
                    state_s = ST_SPI_ACC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SPI_ACC: begin
                if (slot_wr_r) begin
                    spi_rdata_s = {DW{1'b0}};
                    spi_rcrc_s  = {CRC_W{1'b0}};
                end else begin
                    spi_rdata_s = i_rdata;
                    spi_rcrc_s  = i_rcrc;
                end
                slot_v_s = 1'b0;
                state_s  = ST_SPI_ACK;
            end
            ST_SPI_ACK: begin
                state_s = ST_IDLE;
            end
            ST_EF_RD: begin
                tmo_cnt_s = 8'd0;
                state_s   = ST_EF_WAIT;
            end
            ST_EF_WAIT: begin
                if (i_efuse_vld) begin
                    state_s = ST_EF_WR;
                end else if (tmo_cnt_r == 8'(EF_TMO)) begin
                    ef_err_s = 1'b1;
                    state_s  = ST_IDLE;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 8'd1;
                end
            end
            ST_EF_WR: begin
                if (idx_r == 4'(EF_NUM - 1)) begin
                    ef_done_s = 1'b1;
                    state_s   = ST_IDLE;
                end else begin
                    idx_s   = idx_r + 4'd1;
                    state_s = ST_EF_RD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        spi_ack_s = 1'b0;
        ef_rd_s   = 1'b0;
        ef_idx_s  = 4'd0;
        ef_busy_s = 1'b0;
        wen_s     = 1'b0;
        ren_s     = 1'b0;
        addr_s    = {AW{1'b0}};
        wdata_s   = {DW{1'b0}};
        crc_s     = {CRC_W{1'b0}};
        spi_en_s  = 1'b0;
        ef_en_s   = 1'b0;
        case (state_s)
            ST_SPI_ACC: begin
                wen_s    = slot_wr_r;
                ren_s    = !slot_wr_r;
                addr_s   = slot_addr_r;
                wdata_s  = slot_wdata_r;
                crc_s    = slot_crc_r;
                spi_en_s = 1'b1;
            end
            ST_SPI_ACK: begin
                spi_ack_s = 1'b1;
            end
            ST_EF_RD: begin
                ef_rd_s   = 1'b1;
                ef_idx_s  = idx_s;
                ef_busy_s = 1'b1;
            end
            ST_EF_WAIT: begin
                ef_busy_s = 1'b1;
            end
            ST_EF_WR: begin
                // EF_WR is only entered on a valid efuse word, so the bus register captures it.
                wen_s     = 1'b1;
                addr_s    = EF_BASE_ADDR + AW'(idx_r);
                wdata_s   = i_efuse_data;
                crc_s     = i_efuse_crc;
                ef_en_s   = 1'b1;
                ef_busy_s = 1'b1;
            end
            default: begin
                ef_busy_s = 1'b0;
            end
        endcase
    end

    // State, slot, status and output registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r      <= ST_IDLE;
            slot_v_r     <= 1'b0;
            slot_wr_r    <= 1'b0;
            slot_addr_r  <= {AW{1'b0}};
            slot_wdata_r <= {DW{1'b0}};
            slot_crc_r   <= {CRC_W{1'b0}};
            ef_pend_r    <= 1'b0;
            idx_r        <= 4'd0;
            tmo_cnt_r    <= 8'd0;
            spi_rdata_r  <= {DW{1'b0}};
            spi_rcrc_r   <= {CRC_W{1'b0}};
            spi_err_r    <= 1'b0;
            ef_done_r    <= 1'b0;
            ef_err_r     <= 1'b0;
            spi_ack_r    <= 1'b0;
            ef_rd_r      <= 1'b0;
            ef_idx_r     <= 4'd0;
            ef_busy_r    <= 1'b0;
            wen_r        <= 1'b0;
            ren_r        <= 1'b0;
            addr_r       <= {AW{1'b0}};
            wdata_r      <= {DW{1'b0}};
            crc_r        <= {CRC_W{1'b0}};
            spi_en_r     <= 1'b0;
            ef_en_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            slot_v_r     <= slot_v_s;
            slot_wr_r    <= slot_wr_s;
            slot_addr_r  <= slot_addr_s;
            slot_wdata_r <= slot_wdata_s;
            slot_crc_r   <= slot_crc_s;
            ef_pend_r    <= ef_pend_s;
            idx_r        <= idx_s;
            tmo_cnt_r    <= tmo_cnt_s;
            spi_rdata_r  <= spi_rdata_s;
            spi_rcrc_r   <= spi_rcrc_s;
            spi_err_r    <= spi_err_s;
            ef_done_r    <= ef_done_s;
            ef_err_r     <= ef_err_s;
            spi_ack_r    <= spi_ack_s;
            ef_rd_r      <= ef_rd_s;
            ef_idx_r     <= ef_idx_s;
            ef_busy_r    <= ef_busy_s;
            wen_r        <= wen_s;
            ren_r        <= ren_s;
            addr_r       <= addr_s;
            wdata_r      <= wdata_s;
            crc_r        <= crc_s;
            spi_en_r     <= spi_en_s;
            ef_en_r      <= ef_en_s;
        end
    end

    assign o_spi_ack           = spi_ack_r;
    assign o_spi_rdata         = spi_rdata_r;
    assign o_spi_rcrc          = spi_rcrc_r;
    assign o_spi_err           = spi_err_r;
    assign o_ef_rd             = ef_rd_r;
    assign o_ef_idx            = ef_idx_r;
    assign o_ef_busy           = ef_busy_r;
    assign o_ef_done           = ef_done_r;
    assign o_ef_err            = ef_err_r;
    assign o_wen               = wen_r;
    assign o_ren               = ren_r;
    assign o_addr              = addr_r;
    assign o_wdata             = wdata_r;
    assign o_crc_data          = crc_r;
    assign o_spi_ctrl_reg_en   = spi_en_r;
    assign o_efuse_ctrl_reg_en = ef_en_r;

endmodule
